ddr3_bus_bridge: RTL and testbench

- Initiator for the DDR3 memory-interface user port: drives cmd/addr/wr_data and consumes rd_data.
- Sits between an 8-bit MSX-style byte bus and the 128-bit DDR3 controller; runs in the controller's user clock domain.
- Byte reads fetch one 16-byte line and return the selected byte.
- Byte writes do a read-modify-write of the 16-byte line, because wr_data_mask has 16-bit granularity.

---
 rtl/ddr3_bus_bridge.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ddr3_bus_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_bus_bridge.sv
// ============================================================================
//  Module   : ddr3_bus_bridge
//  Purpose  : Bridges an 8-bit byte bus onto the 128-bit DDR3 controller user
//             port. Byte reads fetch a 16-byte line and return the addressed
//             byte; byte writes read the line, merge the byte and write the
//             whole line back (mask granularity is too coarse for one byte).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n             user clock / asynchronous active-low reset
//    init_calib_complete    controller calibrated; gates new acceptance
//    bus_valid/bus_ready    byte request handshake
//    bus_write, bus_address, bus_wdata   latched request
//    bus_rdata, bus_rdata_en             read byte + one-cycle strobe
//    timeout_error          sticky read-wait watchdog flag
//    cmd_ready, cmd, cmd_en, addr        controller command channel
//    wr_data_rdy, wr_data, wr_data_en, wr_data_end, wr_data_mask
//    rd_data, rd_data_valid, rd_data_end (unused)
//    sr_req, ref_req, burst              tied low
//  Options
//    DDR3_BRIDGE_LINE_BUFFER_EN : keep the last line read/written and serve
//                                 hits without a DDR read.
// ============================================================================
`default_nettype none

module ddr3_bus_bridge #(
    parameter int          TIMEOUT_BITS  = 10,
    parameter logic [7:0]  TIMEOUT_RDATA = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_calib_complete,
    input  logic         bus_valid,
    output logic         bus_ready,
    input  logic         bus_write,
    input  logic [26:0]  bus_address,
    input  logic [7:0]   bus_wdata,
    output logic [7:0]   bus_rdata,
    output logic         bus_rdata_en,
    output logic         timeout_error,
    input  logic         cmd_ready,
    output logic [2:0]   cmd,
    output logic         cmd_en,
    output logic [27:0]  addr,
    input  logic         wr_data_rdy,
    output logic [127:0] wr_data,
    output logic         wr_data_en,
    output logic         wr_data_end,
    output logic [7:0]   wr_data_mask,
    input  logic [127:0] rd_data,
    input  logic         rd_data_valid,
    input  logic         rd_data_end,
    output logic         sr_req,
    output logic         ref_req,
    output logic         burst
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_MERGE   = 3'd3,
        ST_WR      = 3'd4,
        ST_HIT     = 3'd5
    } state_t;

    localparam logic [2:0] C_CMD_RD = 3'b001;
    localparam logic [2:0] C_CMD_WR = 3'b000;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_bus_ready;
    logic                    r_req_write;
    logic [26:0]             r_req_addr;
    logic [7:0]              r_req_wdata;
    logic [127:0]            r_line;
    logic [TIMEOUT_BITS-1:0] r_wdog;
    logic [7:0]              r_bus_rdata;
    logic                    r_bus_rdata_en;
    logic                    r_timeout_error;

    logic                    w_accept;
    logic                    w_issue_wr;
    logic                    w_wdog_expired;
    logic                    w_hit;

`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
    logic                    r_buf_valid;
    logic [22:0]             r_buf_tag;
`endif

    // Replace byte idx of a line with data.
    function automatic logic [127:0] f_merge(input logic [127:0] line,
                                             input logic [3:0]   idx,
                                             input logic [7:0]   data);
        logic [127:0] res;
        res = line;
        res[{idx, 3'b000} +: 8] = data;
        return res;
    endfunction

    assign w_accept       = bus_valid & r_bus_ready;
    assign w_issue_wr     = cmd_ready & wr_data_rdy;
    assign w_wdog_expired = &r_wdog;

`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
    assign w_hit = r_buf_valid && (r_buf_tag == bus_address[26:4]);
`else
    assign w_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hit)
                        w_next_state = bus_write ? ST_WR : ST_HIT;
                    else
                        w_next_state = ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                if (cmd_ready)
                    w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Data beats the watchdog when both land in the same cycle.
                if (rd_data_valid)
                    w_next_state = r_req_write ? ST_MERGE : ST_IDLE;
                else if (w_wdog_expired)
                    w_next_state = ST_IDLE;
            end
            ST_MERGE: w_next_state = ST_WR;
            ST_WR: begin
                if (w_issue_wr)
                    w_next_state = ST_IDLE;
            end
            ST_HIT:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_bus_ready     <= 1'b0;
            r_req_write     <= 1'b0;
            r_req_addr      <= '0;
            r_req_wdata     <= '0;
            r_line          <= '0;
            r_wdog          <= '0;
            r_bus_rdata     <= '0;
            r_bus_rdata_en  <= 1'b0;
            r_timeout_error <= 1'b0;
`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
            r_buf_valid     <= 1'b0;
            r_buf_tag       <= '0;
`endif
        end else begin
            r_state        <= w_next_state;
            // Ready is only offered from idle with a calibrated controller.
            r_bus_ready    <= (w_next_state == ST_IDLE) && init_calib_complete;
            r_bus_rdata_en <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_write <= bus_write;
                        r_req_addr  <= bus_address;
                        r_req_wdata <= bus_wdata;
                        // A write hit merges directly into the buffered line.
                        if (w_hit && bus_write)
                            r_line <= f_merge(r_line, bus_address[3:0], bus_wdata);
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_ready)
                        r_wdog <= '0;
                end
                ST_RD_WAIT: begin
                    if (rd_data_valid) begin
                        r_line <= rd_data;
                        if (!r_req_write) begin
                            r_bus_rdata    <= rd_data[{r_req_addr[3:0], 3'b000} +: 8];
                            r_bus_rdata_en <= 1'b1;
                        end
`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= r_req_addr[26:4];
`endif
                    end else if (w_wdog_expired) begin
                        r_timeout_error <= 1'b1;
                        if (!r_req_write) begin
                            r_bus_rdata    <= TIMEOUT_RDATA;
                            r_bus_rdata_en <= 1'b1;
                        end
`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
                        r_buf_valid <= 1'b0;
`endif
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_MERGE: begin
                    r_line <= f_merge(r_line, r_req_addr[3:0], r_req_wdata);
                end
                ST_WR: begin
`ifdef DDR3_BRIDGE_LINE_BUFFER_EN
                    if (w_issue_wr) begin
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= r_req_addr[26:4];
                    end
`endif
                end
                ST_HIT: begin
                    r_bus_rdata    <= r_line[{r_req_addr[3:0], 3'b000} +: 8];
                    r_bus_rdata_en <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd        = C_CMD_WR;
        cmd_en     = 1'b0;
        wr_data_en = 1'b0;
        case (r_state)
            ST_RD_CMD: begin
                cmd    = C_CMD_RD;
                cmd_en = 1'b1;
            end
            ST_WR: begin
                // Command and data go out together, only when both sides accept.
                if (w_issue_wr) begin
                    cmd_en     = 1'b1;
                    wr_data_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign addr          = {2'b00, r_req_addr[26:4], 3'b000};
    assign wr_data       = r_line;
    assign wr_data_end   = wr_data_en;
    assign wr_data_mask  = 8'h00;
    assign bus_ready     = r_bus_ready;
    assign bus_rdata     = r_bus_rdata;
    assign bus_rdata_en  = r_bus_rdata_en;
    assign timeout_error = r_timeout_error;
    assign sr_req        = 1'b0;
    assign ref_req       = 1'b0;
    assign burst         = 1'b0;

    // rd_data_end carries no information for single-beat BL8 reads.
    logic w_unused_ok;
    assign w_unused_ok = rd_data_end;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_bus_bridge.sv
// ============================================================================
//  Module   : tb_ddr3_bus_bridge
//  Purpose  : Directed self-checking bench for ddr3_bus_bridge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ddr3_bus_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_calib_complete;
    logic         bus_valid;
    logic         bus_ready;
    logic         bus_write;
    logic [26:0]  bus_address;
    logic [7:0]   bus_wdata;
    logic [7:0]   bus_rdata;
    logic         bus_rdata_en;
    logic         timeout_error;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic         cmd_en;
    logic [27:0]  addr;
    logic         wr_data_rdy;
    logic [127:0] wr_data;
    logic         wr_data_en;
    logic         wr_data_end;
    logic [7:0]   wr_data_mask;
    logic [127:0] rd_data;
    logic         rd_data_valid;
    logic         rd_data_end;
    logic         sr_req;
    logic         ref_req;
    logic         burst;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ddr3_bus_bridge #(
        .TIMEOUT_BITS  (10),
        .TIMEOUT_RDATA (8'hFF)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_calib_complete (init_calib_complete),
        .bus_valid           (bus_valid),
        .bus_ready           (bus_ready),
        .bus_write           (bus_write),
        .bus_address         (bus_address),
        .bus_wdata           (bus_wdata),
        .bus_rdata           (bus_rdata),
        .bus_rdata_en        (bus_rdata_en),
        .timeout_error       (timeout_error),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data             (wr_data),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data_mask        (wr_data_mask),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_data_end         (rd_data_end),
        .sr_req              (sr_req),
        .ref_req             (ref_req),
        .burst               (burst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic ok;
        int   cnt;
        int   strobes;

        rst_n               = 1'b0;
        init_calib_complete = 1'b0;
        bus_valid           = 1'b0;
        bus_write           = 1'b0;
        bus_address         = '0;
        bus_wdata           = '0;
        cmd_ready           = 1'b1;
        wr_data_rdy         = 1'b1;
        rd_data             = '0;
        rd_data_valid       = 1'b0;
        rd_data_end         = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_bus_ready", bus_ready, 0);
        check("rst_cmd_en",    cmd_en, 0);
        check("rst_cmd",       cmd, 0);
        check("rst_addr",      addr, 0);
        check("rst_wr_data",   wr_data, 0);
        check("rst_bus_rdata", bus_rdata, 0);
        check("rst_timeout",   timeout_error, 0);
        check("const_outputs", {wr_data_mask, sr_req, ref_req, burst, wr_data_en, wr_data_end}, 0);

        // ---------------- uncalibrated: nothing accepted ----------------
        rst_n     = 1'b1;
        bus_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_ready !== 1'b0 || cmd_en !== 1'b0) ok = 1'b0;
        end
        check("nocal_quiet", ok, 1);
        bus_valid           = 1'b0;
        init_calib_complete = 1'b1;
        tick();
        check("cal_ready", bus_ready, 1);

        // ---------------- read 0x13, byte 3 = A5 ----------------
        bus_valid   = 1'b1;
        bus_write   = 1'b0;
        bus_address = 27'h0000013;
        tick();                          // accepted at this edge
        bus_valid = 1'b0;
        check("rd_cmd_en",  cmd_en, 1);
        check("rd_cmd",     cmd, 3'b001);
        check("rd_addr",    addr, 28'h0000008);   // {2'b00, 23'h1, 3'b000}
        check("rd_ready_lo", bus_ready, 0);
        tick();                          // command taken, now waiting
        check("rd_cmd_en_drop", cmd_en, 0);
        rd_data       = 128'h0F0E0D0C_0B0A0908_07060504_A5020100;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        check("rd_rdata_en", bus_rdata_en, 1);
        check("rd_rdata",    bus_rdata, 8'hA5);
        check("rd_ready_back", bus_ready, 1);
        tick();
        check("rd_rdata_en_single", bus_rdata_en, 0);

        // ---------------- write 5A to 0x7FFFFFF (k=15) ----------------
        bus_valid   = 1'b1;
        bus_write   = 1'b1;
        bus_address = 27'h7FFFFFF;
        bus_wdata   = 8'h5A;
        tick();
        bus_valid = 1'b0;
        check("wr_rdcmd", {cmd_en, cmd}, {1'b1, 3'b001});
        check("wr_addr",  addr, 28'h3FFFFF8);
        tick();
        rd_data       = '0;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        check("wr_no_early_strobe", {wr_data_en, bus_rdata_en}, 0);
        tick();
        check("wr_strobe",  {cmd_en, cmd, wr_data_en, wr_data_end}, {1'b1, 3'b000, 1'b1, 1'b1});
        check("wr_data",    wr_data, {8'h5A, 120'h0});
        check("wr_mask",    wr_data_mask, 8'h00);
        tick();
        check("wr_strobe_single", wr_data_en, 0);

        // ---------------- write with controller back-pressure ----------------
        cmd_ready   = 1'b0;
        wr_data_rdy = 1'b0;
        bus_valid   = 1'b1;
        bus_write   = 1'b1;
        bus_address = 27'h0000025;
        bus_wdata   = 8'h3C;
        tick();
        bus_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cmd_en !== 1'b1 || cmd !== 3'b001 || addr !== 28'h0000010) ok = 1'b0;
            tick();
        end
        check("stall_cmd_held", ok, 1);
        cmd_ready = 1'b1;
        tick();
        rd_data       = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        tick();                          // merge cycle done, now in write state
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (wr_data_en !== 1'b0 || cmd_en !== 1'b0) ok = 1'b0;
            tick();
        end
        check("stall_wr_quiet", ok, 1);
        wr_data_rdy = 1'b1;
        #1;
        check("stall_wr_data", wr_data, 128'hFFEEDDCC_BBAA9988_77663C44_33221100);
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            if (wr_data_en === 1'b1 && cmd_en === 1'b1) strobes++;
            tick();
        end
        check("stall_one_issue", strobes, 1);

        // ---------------- read-wait timeout ----------------
        bus_valid   = 1'b1;
        bus_write   = 1'b0;
        bus_address = 27'h0000040;
        tick();
        bus_valid = 1'b0;
        tick();                          // in read-wait, watchdog cleared
        check("to_flag_before", timeout_error, 0);
        cnt = 0;
        while (bus_rdata_en !== 1'b1 && cnt < 1100) begin
            tick();
            cnt++;
        end
        check("to_cycles", cnt, 1024);
        check("to_rdata",  bus_rdata, 8'hFF);
        check("to_flag",   timeout_error, 1);
        // next read completes normally; the flag stays set
        bus_valid   = 1'b1;
        bus_address = 27'h0000001;
        tick();
        bus_valid = 1'b0;
        tick();
        rd_data       = 128'h0F0E0D0C_0B0A0908_07060504_A5020100;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        check("to_next_rdata", {bus_rdata_en, bus_rdata}, {1'b1, 8'h01});
        check("to_sticky",     timeout_error, 1);

        // ---------------- reset during read-wait ----------------
        bus_valid   = 1'b1;
        bus_address = 27'h0000013;
        tick();
        bus_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_async", {timeout_error, bus_ready}, 0);
        tick();
        rst_n         = 1'b1;
        rd_data_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (bus_rdata_en !== 1'b0 || cmd_en !== 1'b0 || wr_data_en !== 1'b0) ok = 1'b0;
            tick();
        end
        rd_data_valid = 1'b0;
        check("arst_stray_ignored", ok, 1);
        check("arst_outputs", {bus_rdata, addr, cmd, timeout_error}, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_ready",   bus_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
